proj_topk_sorter: RTL and testbench
===================================

PROJ_TOPK_SORTER -- requirements
Module: proj_topk_sorter

Interface
REQ-001 SHALL have parameter K, default 8: number of smallest entries retained, K >= 2.
REQ-002 SHALL have parameter SIGNATURE_LEN, default 32: signature width in bits.
REQ-003 SHALL have parameter INDICE_LEN, default 8: index width in bits.
REQ-004 SHALL have parameter DEDUP, default 1: when 1, a signature equal to a stored valid signature is discarded.
REQ-005 SHALL have port in_clk, input, 1: the single clock.
REQ-006 SHALL have port in_rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1: input beat valid.
REQ-008 SHALL have port out_in_ready, output, 1: block accepts a beat.
REQ-009 SHALL have port in_signature, input, SIGNATURE_LEN: hash value of the beat.
REQ-010 SHALL have port in_index, input, INDICE_LEN: index paired with the signature.
REQ-011 SHALL have port in_last, input, 1: final beat of the current set.
REQ-012 SHALL have port in_clear, input, 1: synchronous flush.
REQ-013 SHALL have port out_valid, output, 1: result list is stable and valid.
REQ-014 SHALL have port in_out_ready, input, 1: downstream consumes the result.
REQ-015 SHALL have port out_smallest_idx, output, K x INDICE_LEN: indices in ascending signature order.
REQ-016 SHALL have port out_smallest_sig, output, K x SIGNATURE_LEN: matching signatures.
REQ-017 SHALL have port out_count, output, $clog2(K+1): number of valid slots.

Function
REQ-018 SHALL hold K slots {valid, signature, index} kept sorted ascending, with valid slots contiguous from slot 0; an empty slot compares as +infinity.
REQ-019 SHALL use a two-state FSM: COLLECT (out_in_ready=1, out_valid=0) and HOLD (out_in_ready=0, out_valid=1).
REQ-020 SHALL accept a beat only when in_valid and out_in_ready are both 1 in COLLECT.
REQ-021 SHALL insert an accepted beat at position p, where p = count of valid slots with signature <= in_signature; slots p..K-2 shift up one, and the old slot K-1 is lost.
REQ-022 SHALL discard the beat when p == K, leaving the array unchanged.
REQ-023 SHALL break ties stably: a new equal signature goes after existing entries when DEDUP=0, and the beat is discarded when DEDUP=1.
REQ-024 SHALL complete each insertion in one cycle, with the updated list visible on outputs the cycle after acceptance, so back-to-back beats are sustained.
REQ-025 SHALL, on an accepted beat with in_last=1, apply that beat (inserted or discarded) and enter HOLD next cycle.
REQ-026 SHALL, in HOLD with in_out_ready=1, clear all slots and return to COLLECT next cycle.
REQ-027 SHALL keep out_valid asserted and the list stable in HOLD until in_out_ready=1.
REQ-028 SHALL, when in_clear=1 in any state, clear all slots and enter COLLECT next cycle; in_clear overrides any beat accepted in the same cycle.
REQ-029 SHALL keep out_count equal to the number of valid slots, saturating at K.
REQ-030 SHALL drive invalid slots as index 0 and signature all-ones.

Reset
REQ-031 SHALL, when in_rst_n=0, immediately and asynchronously force: FSM=COLLECT, all slots invalid, out_valid=0, out_count=0, out_smallest_idx=0, out_smallest_sig=all-ones.
REQ-032 SHALL discard any set in progress when reset occurs mid-operation, with no partial result emitted.

Structure
REQ-033 SHALL place the slot struct typedef, FSM state enum and default K/width constants in proj_pkg.
REQ-034 SHALL implement one sub-module, proj_topk_slot: per-slot compare, keep/shift/insert select and register.

Verification (K=4, DEDUP=1 unless stated)
REQ-035 SHALL test descending input: sigs 0xA0,0x90,...,0x10 (idx 10..1), last on final beat -> out_valid next cycle, idx {1,2,3,4}, count 4.
REQ-036 SHALL test ascending input: sigs 0x01..0x0A (idx 1..10) -> idx {1,2,3,4}; beats 5..10 are discarded.
REQ-037 SHALL test duplicates: sigs 0x05,0x05,0x03 (idx 1,2,3), last -> idx {3,1}, count 2; with DEDUP=0 -> idx {3,1,2}.
REQ-038 SHALL test backpressure: HOLD with in_out_ready=0 for 5 cycles while in_valid=1 -> out_in_ready=0 and the list unchanged; after in_out_ready=1, count=0 next cycle.
REQ-039 SHALL test in_clear together with a valid beat after 3 insertions -> next cycle count=0 and the beat is not stored.
REQ-040 SHALL test in_rst_n low mid-set, then 2K random beats with last -> the result equals the K smallest by scoreboard, ascending at every cycle.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared types and default sizing for the top-K signature sorter.
package proj_pkg;

    localparam int K_DEFAULT             = 8;
    localparam int SIGNATURE_LEN_DEFAULT = 32;
    localparam int INDICE_LEN_DEFAULT    = 8;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    // Slot layout at the default widths; an empty slot reads as {0, all-ones, 0}.
    typedef struct packed {
        logic                             valid;
        logic [SIGNATURE_LEN_DEFAULT-1:0] sig;
        logic [INDICE_LEN_DEFAULT-1:0]    idx;
    } slot_t;

endpackage

// File: rtl/proj_topk_slot.sv
// One sorted-list slot: compares its entry with the incoming signature and
// keeps, inserts the new beat, or takes the neighbour above it.
module proj_topk_slot
    import proj_pkg::*;
#(
    parameter int SIGNATURE_LEN = SIGNATURE_LEN_DEFAULT,
    parameter int INDICE_LEN    = INDICE_LEN_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_load,
    input  logic [SIGNATURE_LEN-1:0] i_new_sig,
    input  logic [INDICE_LEN-1:0]    i_new_idx,
    input  logic                     i_prev_le,
    input  logic                     i_prev_valid,
    input  logic [SIGNATURE_LEN-1:0] i_prev_sig,
    input  logic [INDICE_LEN-1:0]    i_prev_idx,
    output logic                     o_le,
    output logic                     o_eq,
    output logic                     o_valid,
    output logic [SIGNATURE_LEN-1:0] o_sig,
    output logic [INDICE_LEN-1:0]    o_idx
);

    logic                     r_valid;
    logic [SIGNATURE_LEN-1:0] r_sig;
    logic [INDICE_LEN-1:0]    r_idx;

    // Valid entries with sig <= new form a prefix, so the first slot that is
    // not "le" while its upper neighbour is becomes the insertion point.
    assign o_le    = r_valid && (r_sig <= i_new_sig);
    assign o_eq    = r_valid && (r_sig == i_new_sig);
    assign o_valid = r_valid;
    assign o_sig   = r_sig;
    assign o_idx   = r_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_sig   <= '1;
            r_idx   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_sig   <= '1;
            r_idx   <= '0;
        end else if (i_load && !o_le) begin
            if (i_prev_le) begin
                r_valid <= 1'b1;
                r_sig   <= i_new_sig;
                r_idx   <= i_new_idx;
            end else begin
                r_valid <= i_prev_valid;
                r_sig   <= i_prev_sig;
                r_idx   <= i_prev_idx;
            end
        end
    end

endmodule

// File: rtl/proj_topk_sorter.sv
// Keeps the K smallest signatures of a beat stream in ascending order and
// presents the list after the last beat until the consumer takes it.
module proj_topk_sorter
    import proj_pkg::*;
#(
    parameter int K             = K_DEFAULT,
    parameter int SIGNATURE_LEN = SIGNATURE_LEN_DEFAULT,
    parameter int INDICE_LEN    = INDICE_LEN_DEFAULT,
    parameter int DEDUP         = 1
) (
    input  logic                               in_clk,
    input  logic                               in_rst_n,
    input  logic                               in_valid,
    output logic                               out_in_ready,
    input  logic [SIGNATURE_LEN-1:0]           in_signature,
    input  logic [INDICE_LEN-1:0]              in_index,
    input  logic                               in_last,
    input  logic                               in_clear,
    output logic                               out_valid,
    input  logic                               in_out_ready,
    output logic [K-1:0][INDICE_LEN-1:0]       out_smallest_idx,
    output logic [K-1:0][SIGNATURE_LEN-1:0]    out_smallest_sig,
    output logic [$clog2(K+1)-1:0]             out_count,
    output state_e                             out_dbg_state
);

    localparam int CNT_W = $clog2(K+1);

    state_e                          r_state;
    logic                            r_in_ready;
    logic                            r_out_valid;
    logic [K-1:0]                    w_le;
    logic [K-1:0]                    w_eq;
    logic [K-1:0]                    w_valid;
    logic [K-1:0]                    w_prev_le;
    logic [K-1:0]                    w_prev_valid;
    logic [K-1:0][SIGNATURE_LEN-1:0] w_prev_sig;
    logic [K-1:0][INDICE_LEN-1:0]    w_prev_idx;
    logic                            w_accept;
    logic                            w_dup;
    logic                            w_load;
    logic                            w_flush;
    logic [CNT_W-1:0]                w_count;

    // Handshake: a beat transfers on any cycle with in_valid && out_in_ready;
    // the result list transfers on any cycle with out_valid && in_out_ready.
    assign w_accept = in_valid && r_in_ready;
    assign w_dup    = (DEDUP != 0) && (|w_eq);
    assign w_load   = w_accept && !in_clear && !w_le[K-1] && !w_dup;
    assign w_flush  = in_clear || ((r_state == ST_HOLD) && in_out_ready);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state     <= ST_COLLECT;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (in_clear) begin
            r_state     <= ST_COLLECT;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_accept && in_last) begin
                        r_state     <= ST_HOLD;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (in_out_ready) begin
                        r_state     <= ST_COLLECT;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_COLLECT;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar j = 0; j < K; j++) begin : g_slot
        if (j == 0) begin : g_head
            assign w_prev_le[j]    = 1'b1;
            assign w_prev_valid[j] = 1'b0;
            assign w_prev_sig[j]   = '1;
            assign w_prev_idx[j]   = '0;
        end else begin : g_body
            assign w_prev_le[j]    = w_le[j-1];
            assign w_prev_valid[j] = w_valid[j-1];
            assign w_prev_sig[j]   = out_smallest_sig[j-1];
            assign w_prev_idx[j]   = out_smallest_idx[j-1];
        end

        proj_topk_slot #(
            .SIGNATURE_LEN (SIGNATURE_LEN),
            .INDICE_LEN    (INDICE_LEN)
        ) u_slot (
            .i_clk        (in_clk),
            .i_rst_n      (in_rst_n),
            .i_flush      (w_flush),
            .i_load       (w_load),
            .i_new_sig    (in_signature),
            .i_new_idx    (in_index),
            .i_prev_le    (w_prev_le[j]),
            .i_prev_valid (w_prev_valid[j]),
            .i_prev_sig   (w_prev_sig[j]),
            .i_prev_idx   (w_prev_idx[j]),
            .o_le         (w_le[j]),
            .o_eq         (w_eq[j]),
            .o_valid      (w_valid[j]),
            .o_sig        (out_smallest_sig[j]),
            .o_idx        (out_smallest_idx[j])
        );
    end

    always_comb begin
        w_count = '0;
        for (int j = 0; j < K; j++) begin
            w_count = w_count + CNT_W'(w_valid[j]);
        end
    end

    assign out_in_ready  = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_count     = w_count;
    assign out_dbg_state = r_state;

endmodule

// File: tb/tb_proj_topk_sorter.sv
// Bench for proj_topk_sorter: two K=4 instances (DEDUP=1 and DEDUP=0) share
// one stimulus stream; results are checked against queued expectations.
`timescale 1ns/1ps
module tb_proj_topk_sorter;
    import proj_pkg::*;

    localparam int K  = 4;
    localparam int SL = 32;
    localparam int IL = 8;
    localparam int CW = $clog2(K+1);
    localparam int EW = CW + K*IL + K*SL;
    localparam int NR = 2*K;
    localparam logic [SL-1:0] NONE = '1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic in_clear = 1'b0;
    logic out_ready = 1'b1;
    logic [SL-1:0] in_sig = '0;
    logic [IL-1:0] in_idx = '0;

    logic rdy1, vld1, rdy0, vld0;
    logic [K-1:0][IL-1:0] idx1, idx0;
    logic [K-1:0][SL-1:0] sig1, sig0;
    logic [CW-1:0] cnt1, cnt0;
    state_e st1, st0;

    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q0[$];
    int n_chk = 0;
    int n_fail = 0;
    logic pv1 = 1'b0;
    logic pv0 = 1'b0;
    logic [SL-1:0] rs [NR];
    logic [IL-1:0] ri [NR];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200us");
        $fatal(1, "timeout");
    end

    proj_topk_sorter #(.K(K), .SIGNATURE_LEN(SL), .INDICE_LEN(IL), .DEDUP(1)) dut1 (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .out_in_ready(rdy1),
        .in_signature(in_sig), .in_index(in_idx), .in_last(in_last), .in_clear(in_clear),
        .out_valid(vld1), .in_out_ready(out_ready), .out_smallest_idx(idx1),
        .out_smallest_sig(sig1), .out_count(cnt1), .out_dbg_state(st1)
    );

    proj_topk_sorter #(.K(K), .SIGNATURE_LEN(SL), .INDICE_LEN(IL), .DEDUP(0)) dut0 (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .out_in_ready(rdy0),
        .in_signature(in_sig), .in_index(in_idx), .in_last(in_last), .in_clear(in_clear),
        .out_valid(vld0), .in_out_ready(out_ready), .out_smallest_idx(idx0),
        .out_smallest_sig(sig0), .out_count(cnt0), .out_dbg_state(st0)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pk(input int c, input int i0, input int i1, input int i2,
                                          input int i3, input logic [SL-1:0] s0, input logic [SL-1:0] s1,
                                          input logic [SL-1:0] s2, input logic [SL-1:0] s3);
        logic [K-1:0][IL-1:0] ia;
        logic [K-1:0][SL-1:0] sa;
        ia[0] = IL'(i0); ia[1] = IL'(i1); ia[2] = IL'(i2); ia[3] = IL'(i3);
        sa[0] = s0; sa[1] = s1; sa[2] = s2; sa[3] = s3;
        return {CW'(c), ia, sa};
    endfunction

    // Reference: repeatedly pick the smallest remaining signature, earliest
    // beat first on ties; with dedup, later copies of a picked value are dropped.
    function automatic logic [EW-1:0] model(input logic [SL-1:0] s [NR], input logic [IL-1:0] ix [NR],
                                             input bit dedup);
        logic [K-1:0][IL-1:0] ia;
        logic [K-1:0][SL-1:0] sa;
        bit used [NR];
        int c = 0;
        ia = '0;
        sa = '1;
        for (int j = 0; j < NR; j++) used[j] = 1'b0;
        for (int k = 0; k < K; k++) begin
            int best = -1;
            for (int j = 0; j < NR; j++)
                if (!used[j] && (best < 0 || s[j] < s[best])) best = j;
            if (best >= 0) begin
                used[best] = 1'b1;
                if (dedup)
                    for (int j = 0; j < NR; j++) if (s[j] == s[best]) used[j] = 1'b1;
                ia[c] = ix[best];
                sa[c] = s[best];
                c++;
            end
        end
        return {CW'(c), ia, sa};
    endfunction

    function automatic bit ordered(input logic [K-1:0][IL-1:0] ia, input logic [K-1:0][SL-1:0] sa,
                                   input logic [CW-1:0] c);
        bit ok = 1'b1;
        if (int'(c) > K) ok = 1'b0;
        for (int j = 0; j < K; j++) begin
            if (j < int'(c)) begin
                if (j + 1 < int'(c) && sa[j] > sa[j+1]) ok = 1'b0;
            end else if (ia[j] != '0 || sa[j] != NONE) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [SL-1:0] s, input logic [IL-1:0] i, input logic l);
        int w = 0;
        while (!rdy1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!rdy1) check("ready_timeout", EW'(rdy1), EW'(1));
        in_valid = 1'b1;
        in_sig   = s;
        in_idx   = i;
        in_last  = l;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_empty(input string name);
        check(name, {cnt1, idx1, sig1}, pk(0, 0, 0, 0, 0, NONE, NONE, NONE, NONE));
        check({name, "_valid"}, EW'(vld1), EW'(0));
        check({name, "_ready"}, EW'(rdy1), EW'(1));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (vld1 && !pv1) begin
                if (exp_q1.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_result_dedup1: got %h expected no result", {cnt1, idx1, sig1});
                end else check("result_dedup1", {cnt1, idx1, sig1}, exp_q1.pop_front());
            end
            if (vld0 && !pv0) begin
                if (exp_q0.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_result_dedup0: got %h expected no result", {cnt0, idx0, sig0});
                end else check("result_dedup0", {cnt0, idx0, sig0}, exp_q0.pop_front());
            end
            check("order_dedup1", EW'(ordered(idx1, sig1, cnt1)), EW'(1));
            check("order_dedup0", EW'(ordered(idx0, sig0, cnt0)), EW'(1));
        end
        pv1 <= rst_n && vld1;
        pv0 <= rst_n && vld0;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [EW-1:0] hold_exp;

        repeat (3) @(negedge clk);
        check_empty("reset_state");
        check("reset_fsm", EW'(st1), EW'(ST_COLLECT));
        rst_n = 1'b1;
        @(negedge clk);

        // descending 0xA0..0x10, idx 10..1
        exp_q1.push_back(pk(4, 1, 2, 3, 4, 32'h10, 32'h20, 32'h30, 32'h40));
        exp_q0.push_back(pk(4, 1, 2, 3, 4, 32'h10, 32'h20, 32'h30, 32'h40));
        for (int i = 0; i < 10; i++) send(SL'(160 - 16*i), IL'(10 - i), i == 9);
        check("desc_latency_valid", EW'(vld1), EW'(1));
        check("desc_count", EW'(cnt1), EW'(4));
        idle();
        check_empty("desc_drain");

        // ascending 0x01..0x0A, idx 1..10
        exp_q1.push_back(pk(4, 1, 2, 3, 4, 32'h1, 32'h2, 32'h3, 32'h4));
        exp_q0.push_back(pk(4, 1, 2, 3, 4, 32'h1, 32'h2, 32'h3, 32'h4));
        for (int i = 1; i <= 10; i++) send(SL'(i), IL'(i), i == 10);
        idle();

        // duplicates: 0x05, 0x05, 0x03
        exp_q1.push_back(pk(2, 3, 1, 0, 0, 32'h3, 32'h5, NONE, NONE));
        exp_q0.push_back(pk(3, 3, 1, 2, 0, 32'h3, 32'h5, 32'h5, NONE));
        send(32'h5, 8'd1, 1'b0);
        send(32'h5, 8'd2, 1'b0);
        send(32'h3, 8'd3, 1'b1);
        idle();
        check_empty("dup_drain");

        // backpressure in HOLD with in_valid held high
        out_ready = 1'b0;
        hold_exp = pk(2, 8, 7, 0, 0, 32'h11, 32'h33, NONE, NONE);
        exp_q1.push_back(hold_exp);
        exp_q0.push_back(hold_exp);
        send(32'h33, 8'd7, 1'b0);
        send(32'h11, 8'd8, 1'b1);
        in_sig = 32'h01;
        in_idx = 8'd99;
        in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp_ready_low", EW'(rdy1), EW'(0));
            check("bp_valid_high", EW'(vld1), EW'(1));
            check("bp_list_dedup1", {cnt1, idx1, sig1}, hold_exp);
            check("bp_list_dedup0", {cnt0, idx0, sig0}, hold_exp);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_empty("bp_release");

        // in_clear together with an accepted beat after 3 insertions
        send(32'h20, 8'd1, 1'b0);
        send(32'h10, 8'd2, 1'b0);
        send(32'h30, 8'd3, 1'b0);
        check("clear_pre_count", EW'(cnt1), EW'(3));
        in_clear = 1'b1;
        send(32'h05, 8'd9, 1'b1);
        check_empty("clear_result");
        idle();
        exp_q1.push_back(pk(1, 4, 0, 0, 0, 32'h40, NONE, NONE, NONE));
        exp_q0.push_back(pk(1, 4, 0, 0, 0, 32'h40, NONE, NONE, NONE));
        send(32'h40, 8'd4, 1'b1);
        idle();

        // asynchronous reset mid-set, then 2K random beats
        send(32'h50, 8'd1, 1'b0);
        send(32'h60, 8'd2, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_empty("async_reset");
        check("async_reset_fsm", EW'(st1), EW'(ST_COLLECT));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            rs[i] = SL'($urandom_range(0, 15));
            ri[i] = IL'(i + 1);
        end
        exp_q1.push_back(model(rs, ri, 1'b1));
        exp_q0.push_back(model(rs, ri, 1'b0));
        for (int i = 0; i < NR; i++) send(rs[i], ri[i], i == NR - 1);
        idle();

        repeat (5) @(negedge clk);
        check("queue_drained_dedup1", EW'(exp_q1.size()), EW'(0));
        check("queue_drained_dedup0", EW'(exp_q0.size()), EW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
